// File: rtl/uart_rx_fifo_core.sv
// UART receiver (5-8 data bits, optional parity, 1/2 stop bits) with false-start and
// break detection, feeding a first-word-fall-through FIFO of per-frame entries.
module uart_rx_fifo_core #(
    parameter int K_W         = 19,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic [K_W-1:0]                k,
    input  logic [1:0]                    data_len,
    input  logic                          pen,
    input  logic                          ohel,
    input  logic                          stop2,
    input  logic                          rd_en,
    input  logic                          clr_ovf,
    output logic [7:0]                    rd_data,
    output logic                          rd_perr,
    output logic                          rd_ferr,
    output logic                          rd_brk,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          ovf,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    logic [K_W-1:0] btc;
    logic [K_W-1:0] cfg_k;
    logic [1:0]     cfg_len;
    logic           cfg_pen, cfg_ohel, cfg_stop2;
    logic [3:0]     bit_idx;
    logic           stop_idx;
    logic [7:0]     shreg;
    logic           par_q;
    logic           stop_err;
    logic           push_q;
    logic [10:0]    frame_q;

    logic           half_tick, bit_tick, sample, last_bit, last_stop, start_ok, frame_done;
    logic [3:0]     n_data, last_idx;
    logic [7:0]     data_w;
    logic           perr_w, ferr_w, brk_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // A bit lasts exactly k clocks: the tick fires at btc = k-1 and btc restarts at 0.
    assign half_tick  = (btc == (k >> 1));
    assign bit_tick   = (btc == cfg_k - K_W'(1));
    assign sample     = bit_tick && (state_q == DATA || state_q == STOP);
    assign n_data     = {2'b00, cfg_len} + 4'd5;
    assign last_idx   = {2'b00, cfg_len} + 4'd4 + {3'b000, cfg_pen};
    assign last_bit   = (bit_idx == last_idx);
    assign last_stop  = (stop_idx == cfg_stop2);
    assign start_ok   = (state_q == START) && (state_d == DATA);
    assign frame_done = sample && (state_q == STOP) && last_stop;

    assign data_w = shreg >> (~cfg_len);
    assign perr_w = cfg_pen & (par_q != (^data_w ^ cfg_ohel));
    assign ferr_w = stop_err | ~rx_s;
    assign brk_w  = (data_w == 8'd0) & (~cfg_pen | ~par_q) & ferr_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!rx_s) state_d = START;
            START:   if (half_tick) state_d = rx_s ? IDLE : DATA;
            DATA:    if (bit_tick && last_bit) state_d = STOP;
            STOP:    if (bit_tick && last_stop) state_d = rx_s ? IDLE : WAIT_HI;
            WAIT_HI: if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btc       <= '0;
            cfg_k     <= '0;
            cfg_len   <= 2'd0;
            cfg_pen   <= 1'b0;
            cfg_ohel  <= 1'b0;
            cfg_stop2 <= 1'b0;
            bit_idx   <= 4'd0;
            stop_idx  <= 1'b0;
            shreg     <= 8'd0;
            par_q     <= 1'b0;
            stop_err  <= 1'b0;
            push_q    <= 1'b0;
            frame_q   <= '0;
        end else begin
            if (state_d != state_q || sample) btc <= '0;
            else                              btc <= btc + K_W'(1);

            if (start_ok) begin
                cfg_k     <= k;
                cfg_len   <= data_len;
                cfg_pen   <= pen;
                cfg_ohel  <= ohel;
                cfg_stop2 <= stop2;
                bit_idx   <= 4'd0;
                stop_idx  <= 1'b0;
                stop_err  <= 1'b0;
                par_q     <= 1'b0;
            end

            if (sample && state_q == DATA) begin
                if (bit_idx < n_data) shreg <= {rx_s, shreg[7:1]};
                else                  par_q <= rx_s;
                bit_idx <= bit_idx + 4'd1;
            end

            if (sample && state_q == STOP) begin
                if (!rx_s) stop_err <= 1'b1;
                stop_idx <= 1'b1;
            end

            push_q <= frame_done;
            if (frame_done) frame_q <= {brk_w, ferr_w, perr_w, data_w};
        end
    end

    logic [10:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [10:0]   head;
    logic          do_push, do_pop, ovf_set;

    assign empty   = (count == '0);
    assign full    = (count == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
    assign do_pop  = rd_en & ~empty;
    assign do_push = push_q & (~full | do_pop);
    assign ovf_set = push_q & full & ~do_pop;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= frame_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
            if (ovf_set)      ovf <= 1'b1;
            else if (clr_ovf) ovf <= 1'b0;
        end
    end

    assign head    = mem[rd_ptr];
    assign rd_data = empty ? 8'd0 : head[7:0];
    assign rd_perr = empty ? 1'b0 : head[8];
    assign rd_ferr = empty ? 1'b0 : head[9];
    assign rd_brk  = empty ? 1'b0 : head[10];

endmodule

// File: tb/tb_uart_rx_fifo_core.sv
// Scoreboard bench for uart_rx_fifo_core: frames are serialised onto rx, the expected
// FIFO entry is queued when the frame is sent and compared when it is popped.
module tb_uart_rx_fifo_core;

    localparam int K_W   = 19;
    localparam int DEPTH = 4;
    localparam int BIT_K = 16;

    logic           clk;
    logic           reset;
    logic           rx;
    logic [K_W-1:0] k;
    logic [1:0]     data_len;
    logic           pen, ohel, stop2, rd_en, clr_ovf;
    logic [7:0]     rd_data;
    logic           rd_perr, rd_ferr, rd_brk, empty, full, ovf, busy;
    logic [2:0]     count;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } entry_t;

    entry_t expQ[$];
    int     vectors    = 0;
    int     miscompares = 0;
    int     modelCount = 0;
    logic   modelOvf   = 1'b0;

    uart_rx_fifo_core #(.K_W(K_W), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .rx(rx), .k(k), .data_len(data_len), .pen(pen),
        .ohel(ohel), .stop2(stop2), .rd_en(rd_en), .clr_ovf(clr_ovf),
        .rd_data(rd_data), .rd_perr(rd_perr), .rd_ferr(rd_ferr), .rd_brk(rd_brk),
        .empty(empty), .full(full), .count(count), .ovf(ovf), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic sendBit(input logic b, input int bk);
        rx = b;
        repeat (bk) @(negedge clk);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("idle_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic pushExpected(input entry_t e);
        if (modelCount < DEPTH) begin
            expQ.push_back(e);
            modelCount++;
        end else begin
            modelOvf = 1'b1;
        end
    endtask

    // Serialise one frame; midK != 0 swaps the k input after data bit 1 is on the line.
    task automatic applyStimulus(input logic [7:0] value, input logic [1:0] len, input logic parEn,
                                 input logic odd, input logic badPar, input logic twoStop,
                                 input logic stop1v, input logic stop2v, input logic [K_W-1:0] midK);
        int         nbits;
        logic [7:0] d;
        logic       goodPar, sentPar;
        entry_t     e;
        nbits    = int'(len) + 5;
        d        = value & (8'hFF >> (8 - nbits));
        goodPar  = (^d) ^ odd;
        sentPar  = badPar ? ~goodPar : goodPar;
        data_len = len;
        pen      = parEn;
        ohel     = odd;
        stop2    = twoStop;
        k        = K_W'(BIT_K);
        @(negedge clk);
        sendBit(1'b0, BIT_K);
        for (int i = 0; i < nbits; i++) begin
            if (i == 2 && midK != 0) k = midK;
            sendBit(d[i], BIT_K);
        end
        if (parEn) sendBit(sentPar, BIT_K);
        sendBit(stop1v, BIT_K);
        if (twoStop) sendBit(stop2v, BIT_K);
        k = K_W'(BIT_K);
        sendBit(1'b1, BIT_K);
        e.data = d;
        e.perr = parEn & badPar;
        e.ferr = ~stop1v | (twoStop & ~stop2v);
        e.brk  = (d == 8'd0) & (~parEn | ~sentPar) & e.ferr;
        pushExpected(e);
        waitIdle(4 * BIT_K);
    endtask

    task automatic popAndCheck(input string tag);
        entry_t e;
        if (expQ.size() == 0) begin
            checkOutput({tag, "_sb_underflow"}, 32'd1, 32'd0);
            return;
        end
        e = expQ.pop_front();
        checkOutput({tag, "_empty"}, 32'(empty), 32'd0);
        checkOutput({tag, "_data"}, 32'(rd_data), 32'(e.data));
        checkOutput({tag, "_perr"}, 32'(rd_perr), 32'(e.perr));
        checkOutput({tag, "_ferr"}, 32'(rd_ferr), 32'(e.ferr));
        checkOutput({tag, "_brk"}, 32'(rd_brk), 32'(e.brk));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        modelCount--;
    endtask

    task automatic checkLevels(input string tag);
        checkOutput({tag, "_count"}, 32'(count), 32'(modelCount));
        checkOutput({tag, "_empty"}, 32'(empty), 32'(modelCount == 0));
        checkOutput({tag, "_full"}, 32'(full), 32'(modelCount == DEPTH));
        checkOutput({tag, "_ovf"}, 32'(ovf), 32'(modelOvf));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        rx       = 1'b1;
        k        = K_W'(BIT_K);
        data_len = 2'd3;
        pen      = 1'b0;
        ohel     = 1'b0;
        stop2    = 1'b0;
        rd_en    = 1'b0;
        clr_ovf  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
        checkOutput("reset_rd_flags", 32'({rd_perr, rd_ferr, rd_brk}), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkLevels("reset");

        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        checkLevels("pop_empty");

        applyStimulus(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
        checkLevels("a5");
        popAndCheck("a5");
        checkLevels("a5_after_pop");

        applyStimulus(8'h41, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, '0);
        popAndCheck("7e1");

        applyStimulus(8'h15, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, '0);
        popAndCheck("5o1");

        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        checkOutput("false_start_busy", 32'(busy), 32'd1);
        waitIdle(4 * BIT_K);
        checkOutput("false_start_idle", 32'(busy), 32'd0);
        checkLevels("false_start");

        data_len = 2'd3;
        pen      = 1'b0;
        stop2    = 1'b0;
        rx       = 1'b0;
        pushExpected('{data: 8'h00, perr: 1'b0, ferr: 1'b1, brk: 1'b1});
        repeat (290) @(negedge clk);
        checkOutput("break_wait_hi", 32'(busy), 32'd1);
        checkLevels("break_low");
        repeat (10) @(negedge clk);
        rx = 1'b1;
        waitIdle(4 * BIT_K);
        checkLevels("break_released");
        popAndCheck("brk");

        for (int v = 1; v <= 5; v++)
            applyStimulus(8'(v), 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
        checkLevels("overflow");
        while (expQ.size() > 0) popAndCheck("ovf_pop");
        checkLevels("ovf_drained");
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf  = 1'b0;
        modelOvf = 1'b0;
        checkLevels("ovf_cleared");

        applyStimulus(8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, K_W'(5));
        popAndCheck("8n2_bad_stop2");

        applyStimulus(8'hC3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, K_W'(40));
        popAndCheck("8n2_good");
        checkLevels("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
